// File: rtl/sc_lanescheduler_pkg.sv
// Shared state encoding, constants and the lane-period helper for the
// Frogger lane scheduler.
package sc_lanescheduler_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        HIT   = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam int         LANE_PERIOD_OFFSET = 4;
    localparam logic [1:0] LEVEL_MAX          = 2'd3;

    // Ticks between shifts for a lane; lower lanes are slower and every
    // level shortens all periods, never below one tick.
    function automatic logic [3:0] lane_period(input int num_lanes,
                                               input int lane,
                                               input logic [1:0] level);
        int p;
        p = num_lanes + LANE_PERIOD_OFFSET - lane - int'(level);
        return (p < 1) ? 4'd1 : 4'(p);
    endfunction

endpackage

// File: rtl/sc_lanescheduler_if.sv
// Game-control bundle between the frog/collision logic (master) and the
// lane scheduler (slave).
interface sc_lanescheduler_if #(
    parameter int NUM_LANES = 4
);
    logic                 SC_LANESCHEDULER_startButton_InLow;
    logic                 SC_LANESCHEDULER_pauseButton_InLow;
    logic                 SC_LANESCHEDULER_collision_InHigh;
    logic                 SC_LANESCHEDULER_goal_InHigh;
    logic [NUM_LANES-1:0] SC_LANESCHEDULER_laneShift_Out;
    logic [NUM_LANES-1:0] SC_LANESCHEDULER_laneDir_Out;
    logic                 SC_LANESCHEDULER_frogClear_OutLow;
    logic [1:0]           SC_LANESCHEDULER_lives_Out;
    logic [1:0]           SC_LANESCHEDULER_level_Out;
    logic [2:0]           SC_LANESCHEDULER_state_Out;
    logic                 SC_LANESCHEDULER_gameOver_OutHigh;

    modport master (
        output SC_LANESCHEDULER_startButton_InLow,
        output SC_LANESCHEDULER_pauseButton_InLow,
        output SC_LANESCHEDULER_collision_InHigh,
        output SC_LANESCHEDULER_goal_InHigh,
        input  SC_LANESCHEDULER_laneShift_Out,
        input  SC_LANESCHEDULER_laneDir_Out,
        input  SC_LANESCHEDULER_frogClear_OutLow,
        input  SC_LANESCHEDULER_lives_Out,
        input  SC_LANESCHEDULER_level_Out,
        input  SC_LANESCHEDULER_state_Out,
        input  SC_LANESCHEDULER_gameOver_OutHigh
    );

    modport slave (
        input  SC_LANESCHEDULER_startButton_InLow,
        input  SC_LANESCHEDULER_pauseButton_InLow,
        input  SC_LANESCHEDULER_collision_InHigh,
        input  SC_LANESCHEDULER_goal_InHigh,
        output SC_LANESCHEDULER_laneShift_Out,
        output SC_LANESCHEDULER_laneDir_Out,
        output SC_LANESCHEDULER_frogClear_OutLow,
        output SC_LANESCHEDULER_lives_Out,
        output SC_LANESCHEDULER_level_Out,
        output SC_LANESCHEDULER_state_Out,
        output SC_LANESCHEDULER_gameOver_OutHigh
    );
endinterface

// File: rtl/sc_lanescheduler_tickprescaler.sv
// Base game-tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// last count as the tick.
module sc_tickprescaler #(
    parameter int TICK_DIV = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Prescale counter; a game init restarts the tick phase from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en) begin
            cnt_r <= (cnt_r == LAST) ? {CW{1'b0}} : cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/sc_lanescheduler.sv
// Frogger game sequencer: paces the obstacle lanes from the game tick, tracks
// lives and level, and strobes the frog position clear.
module sc_lanescheduler
    import sc_lanescheduler_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int TICK_DIV   = 2500000,
    parameter int LIVES_INIT = 3,
    parameter int HIT_TICKS  = 10
) (
    input  logic               SC_STATEMACHINEGAME_CLOCK_50,
    input  logic               SC_STATEMACHINEGAME_RESET_InHigh,
    sc_lanescheduler_if.slave  bus
);
    localparam int               HIT_W     = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;
    localparam logic [HIT_W-1:0] HIT_LAST  = HIT_W'(HIT_TICKS - 1);
    localparam logic [1:0]       LIVES_RST = 2'(LIVES_INIT);

    logic clk;
    logic rst;
    assign clk = SC_STATEMACHINEGAME_CLOCK_50;
    assign rst = SC_STATEMACHINEGAME_RESET_InHigh;

    state_t           state_r;
    logic [1:0]       lives_r;
    logic [1:0]       level_r;
    logic [HIT_W-1:0] hit_cnt_r;
    logic             frog_clear_n_r;
    logic             game_over_r;
    logic             start_prev_r;
    logic             pause_prev_r;

    logic                 start_edge_s;
    logic                 pause_edge_s;
    logic                 tick_s;
    logic                 presc_en_s;
    logic                 run_tick_s;
    logic [NUM_LANES-1:0] lane_shift_s;
    logic [NUM_LANES-1:0] lane_dir_s;

    assign start_edge_s = start_prev_r & ~bus.SC_LANESCHEDULER_startButton_InLow;
    assign pause_edge_s = pause_prev_r & ~bus.SC_LANESCHEDULER_pauseButton_InLow;
    assign presc_en_s   = (state_r == RUN) || (state_r == HIT);
    assign run_tick_s   = tick_s && (state_r == RUN);

    sc_tickprescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en_s),
        .clr  (start_edge_s),
        .tick (tick_s)
    );

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [3:0] period_s;
        logic [3:0] cnt_r;
        logic       shift_r;

        assign period_s        = lane_period(NUM_LANES, i, level_r);
        assign lane_dir_s[i]   = 1'(i % 2);
        assign lane_shift_s[i] = shift_r;

        // Lane counter; >= lets a period that just shrank on level-up wrap at once.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_r   <= 4'd0;
                shift_r <= 1'b0;
            end else begin
                shift_r <= 1'b0;
                if (start_edge_s) begin
                    cnt_r <= 4'd0;
                end else if (run_tick_s) begin
                    if (cnt_r >= period_s - 4'd1) begin
                        cnt_r   <= 4'd0;
                        shift_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
            end
        end
    end

    // Game FSM with lives, level, hit recovery and the frog-clear strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            lives_r        <= LIVES_RST;
            level_r        <= 2'd0;
            hit_cnt_r      <= {HIT_W{1'b0}};
            frog_clear_n_r <= 1'b1;
            game_over_r    <= 1'b0;
            start_prev_r   <= 1'b1;
            pause_prev_r   <= 1'b1;
        end else begin
            start_prev_r   <= bus.SC_LANESCHEDULER_startButton_InLow;
            pause_prev_r   <= bus.SC_LANESCHEDULER_pauseButton_InLow;
            frog_clear_n_r <= 1'b1;
            if (start_edge_s) begin
                state_r        <= RUN;
                lives_r        <= LIVES_RST;
                level_r        <= 2'd0;
                hit_cnt_r      <= {HIT_W{1'b0}};
                frog_clear_n_r <= 1'b0;
                game_over_r    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    RUN: begin
                        if (bus.SC_LANESCHEDULER_collision_InHigh) begin
                            if (lives_r <= 2'd1) begin
                                lives_r     <= 2'd0;
                                state_r     <= OVER;
                                game_over_r <= 1'b1;
                            end else begin
                                lives_r   <= lives_r - 2'd1;
                                hit_cnt_r <= {HIT_W{1'b0}};
                                state_r   <= HIT;
                            end
                        end else if (bus.SC_LANESCHEDULER_goal_InHigh) begin
                            if (level_r != LEVEL_MAX) begin
                                level_r <= level_r + 2'd1;
                            end
                            frog_clear_n_r <= 1'b0;
                        end else if (pause_edge_s) begin
                            state_r <= PAUSE;
                        end
                    end
                    HIT: begin
                        if (tick_s) begin
                            if (hit_cnt_r == HIT_LAST) begin
                                frog_clear_n_r <= 1'b0;
                                state_r        <= RUN;
                            end else begin
                                hit_cnt_r <= hit_cnt_r + {{(HIT_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    PAUSE: begin
                        if (pause_edge_s) begin
                            state_r <= RUN;
                        end
                    end
                    OVER: begin
                        state_r <= OVER;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.SC_LANESCHEDULER_laneShift_Out    = lane_shift_s;
    assign bus.SC_LANESCHEDULER_laneDir_Out      = lane_dir_s;
    assign bus.SC_LANESCHEDULER_frogClear_OutLow = frog_clear_n_r;
    assign bus.SC_LANESCHEDULER_lives_Out        = lives_r;
    assign bus.SC_LANESCHEDULER_level_Out        = level_r;
    assign bus.SC_LANESCHEDULER_state_Out        = state_r;
    assign bus.SC_LANESCHEDULER_gameOver_OutHigh = game_over_r;

endmodule

// File: tb/tb_sc_lanescheduler.sv
// Self-checking bench for sc_lanescheduler: a cycle model pushes expected
// outputs per clock, plus directed timing checks from the game rules.
module tb_sc_lanescheduler;
    localparam int NUM_LANES  = 4;
    localparam int TICK_DIV   = 4;
    localparam int LIVES_INIT = 3;
    localparam int HIT_TICKS  = 2;
    localparam logic [12:0] RST_VEC = {4'b0000, 1'b1, 2'd3, 2'd0, 3'd0, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b0;

    sc_lanescheduler_if #(.NUM_LANES(NUM_LANES)) bus();

    sc_lanescheduler #(
        .NUM_LANES  (NUM_LANES),
        .TICK_DIV   (TICK_DIV),
        .LIVES_INIT (LIVES_INIT),
        .HIT_TICKS  (HIT_TICKS)
    ) dut (
        .SC_STATEMACHINEGAME_CLOCK_50     (clk),
        .SC_STATEMACHINEGAME_RESET_InHigh (rst),
        .bus                              (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [12:0] exp_q[$];

    int   m_state, m_lives, m_level, m_pres, m_hit;
    int   m_lane[NUM_LANES];
    logic m_start_prev, m_pause_prev;

    logic [3:0] o_shift;
    logic       o_clr;
    logic [1:0] o_lives, o_level;
    logic [2:0] o_state;
    logic       o_over;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = LIVES_INIT; m_level = 0; m_pres = 0; m_hit = 0;
        for (int i = 0; i < NUM_LANES; i++) m_lane[i] = 0;
        m_start_prev = 1'b1; m_pause_prev = 1'b1;
    endtask

    // Reference behaviour of one clock edge given the inputs now applied.
    task automatic model_edge();
        logic se, pe, tk, e_clr;
        logic [3:0] e_shift;
        int per;
        se = m_start_prev & ~bus.SC_LANESCHEDULER_startButton_InLow;
        pe = m_pause_prev & ~bus.SC_LANESCHEDULER_pauseButton_InLow;
        m_start_prev = bus.SC_LANESCHEDULER_startButton_InLow;
        m_pause_prev = bus.SC_LANESCHEDULER_pauseButton_InLow;
        tk = (m_state == 1 || m_state == 2) && (m_pres == TICK_DIV - 1);
        e_shift = 4'b0000; e_clr = 1'b1;
        if (se) m_pres = 0;
        else if (m_state == 1 || m_state == 2) m_pres = (m_pres + 1) % TICK_DIV;
        if (se) begin
            m_state = 1; m_lives = LIVES_INIT; m_level = 0; m_hit = 0; e_clr = 1'b0;
            for (int i = 0; i < NUM_LANES; i++) m_lane[i] = 0;
        end else if (m_state == 1) begin
            if (tk) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    per = NUM_LANES + 4 - i - m_level;
                    if (per < 1) per = 1;
                    if (m_lane[i] >= per - 1) begin m_lane[i] = 0; e_shift[i] = 1'b1; end
                    else m_lane[i]++;
                end
            end
            if (bus.SC_LANESCHEDULER_collision_InHigh) begin
                if (m_lives == 1) begin m_lives = 0; m_state = 4; end
                else begin m_lives--; m_hit = 0; m_state = 2; end
            end else if (bus.SC_LANESCHEDULER_goal_InHigh) begin
                if (m_level < 3) m_level++;
                e_clr = 1'b0;
            end else if (pe) m_state = 3;
        end else if (m_state == 2) begin
            if (tk) begin
                if (m_hit == HIT_TICKS - 1) begin e_clr = 1'b0; m_state = 1; end
                else m_hit++;
            end
        end else if (m_state == 3) begin
            if (pe) m_state = 1;
        end
        exp_q.push_back({e_shift, e_clr, 2'(m_lives), 2'(m_level), 3'(m_state), (m_state == 4)});
    endtask

    task automatic sample();
        o_shift = bus.SC_LANESCHEDULER_laneShift_Out;
        o_clr   = bus.SC_LANESCHEDULER_frogClear_OutLow;
        o_lives = bus.SC_LANESCHEDULER_lives_Out;
        o_level = bus.SC_LANESCHEDULER_level_Out;
        o_state = bus.SC_LANESCHEDULER_state_Out;
        o_over  = bus.SC_LANESCHEDULER_gameOver_OutHigh;
    endtask

    function automatic logic [12:0] obs_vec();
        return {o_shift, o_clr, o_lives, o_level, o_state, o_over};
    endfunction

    task automatic step();
        logic [12:0] e;
        model_edge();
        @(posedge clk);
        #1;
        sample();
        e = exp_q.pop_front();
        check_value("cycle", 32'(obs_vec()), 32'(e));
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.SC_LANESCHEDULER_startButton_InLow = 1'b0; step();
        bus.SC_LANESCHEDULER_startButton_InLow = 1'b1;
    endtask

    task automatic pulse_pause();
        bus.SC_LANESCHEDULER_pauseButton_InLow = 1'b0; step();
        bus.SC_LANESCHEDULER_pauseButton_InLow = 1'b1;
    endtask

    task automatic pulse_coll();
        bus.SC_LANESCHEDULER_collision_InHigh = 1'b1; step();
        bus.SC_LANESCHEDULER_collision_InHigh = 1'b0;
    endtask

    task automatic wait_lane(input int lane, input int budget, output int cycles);
        cycles = 0;
        do begin step(); cycles++; end while (!o_shift[lane] && cycles < budget);
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget,
                              output int cycles, output int shifts);
        cycles = 0; shifts = 0;
        do begin
            step(); cycles++; shifts += $countones(o_shift);
        end while (o_state != target && cycles < budget);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, c2, s;
        int lvl_tab[4];
        lvl_tab = '{1, 2, 3, 3};
        bus.SC_LANESCHEDULER_startButton_InLow = 1'b1;
        bus.SC_LANESCHEDULER_pauseButton_InLow = 1'b1;
        bus.SC_LANESCHEDULER_collision_InHigh  = 1'b0;
        bus.SC_LANESCHEDULER_goal_InHigh       = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #2 sample();
        check_value("reset_vec", 32'(obs_vec()), 32'(RST_VEC));
        check_value("lane_dir", 32'(bus.SC_LANESCHEDULER_laneDir_Out), 32'h0000_000a);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
        check_value("idle_state", 32'(o_state), 32'd0);

        // Game start and first lane strobes.
        pulse_start();
        check_value("start_state", 32'(o_state), 32'd1);
        check_value("start_clr", 32'(o_clr), 32'd0);
        check_value("start_lives", 32'(o_lives), 32'd3);
        check_value("start_level", 32'(o_level), 32'd0);
        wait_lane(3, 40, c);
        check_value("lane3_first", 32'(c), 32'd20);
        wait_lane(0, 40, c2);
        check_value("lane0_first", 32'(c + c2), 32'd32);

        // Single collision and recovery.
        pulse_coll();
        check_value("hit_lives", 32'(o_lives), 32'd2);
        check_value("hit_state", 32'(o_state), 32'd2);
        wait_state(3'd1, 40, c, s);
        check_value("hit_len", 32'(c), 32'd7);
        check_value("hit_shifts", 32'(s), 32'd0);
        check_value("hit_exit_clr", 32'(o_clr), 32'd0);

        // Down to game over, then restart.
        pulse_coll();
        check_value("hit2_lives", 32'(o_lives), 32'd1);
        wait_state(3'd1, 40, c, s);
        check_value("hit2_state", 32'(o_state), 32'd1);
        pulse_coll();
        check_value("over_lives", 32'(o_lives), 32'd0);
        check_value("over_state", 32'(o_state), 32'd4);
        check_value("over_flag", 32'(o_over), 32'd1);
        s = 0;
        for (int i = 0; i < 40; i++) begin step(); s += $countones(o_shift); end
        check_value("over_shifts", 32'(s), 32'd0);
        pulse_start();
        check_value("restart_state", 32'(o_state), 32'd1);
        check_value("restart_lives", 32'(o_lives), 32'd3);
        check_value("restart_level", 32'(o_level), 32'd0);
        check_value("restart_over", 32'(o_over), 32'd0);

        // Level saturation.
        for (int k = 0; k < 4; k++) begin
            repeat (3) step();
            bus.SC_LANESCHEDULER_goal_InHigh = 1'b1; step();
            bus.SC_LANESCHEDULER_goal_InHigh = 1'b0;
            check_value("goal_level", 32'(o_level), 32'(lvl_tab[k]));
            check_value("goal_clr", 32'(o_clr), 32'd0);
        end
        wait_lane(3, 60, c);
        wait_lane(3, 60, c);
        check_value("lvl3_lane3_period", 32'(c), 32'd8);
        wait_lane(0, 60, c);
        wait_lane(0, 60, c);
        check_value("lvl3_lane0_period", 32'(c), 32'd20);

        // Pause 8 cycles after a lane0 strobe; 12 run cycles remain after resume.
        repeat (7) step();
        pulse_pause();
        check_value("pause_state", 32'(o_state), 32'd3);
        s = 0;
        for (int i = 0; i < 100; i++) begin
            bus.SC_LANESCHEDULER_collision_InHigh = (i >= 30 && i < 60);
            step();
            s += $countones(o_shift);
        end
        bus.SC_LANESCHEDULER_collision_InHigh = 1'b0;
        check_value("pause_shifts", 32'(s), 32'd0);
        check_value("pause_hold", 32'(o_state), 32'd3);
        check_value("pause_lives", 32'(o_lives), 32'd3);
        pulse_pause();
        check_value("resume_state", 32'(o_state), 32'd1);
        wait_lane(0, 40, c);
        check_value("resume_lane0", 32'(c), 32'd12);

        // Collision and goal together: collision wins.
        bus.SC_LANESCHEDULER_collision_InHigh = 1'b1;
        bus.SC_LANESCHEDULER_goal_InHigh      = 1'b1;
        step();
        bus.SC_LANESCHEDULER_collision_InHigh = 1'b0;
        bus.SC_LANESCHEDULER_goal_InHigh      = 1'b0;
        check_value("both_state", 32'(o_state), 32'd2);
        check_value("both_lives", 32'(o_lives), 32'd2);
        check_value("both_level", 32'(o_level), 32'd3);
        wait_state(3'd1, 40, c, s);

        // Start edge outranks collision.
        bus.SC_LANESCHEDULER_startButton_InLow = 1'b0;
        bus.SC_LANESCHEDULER_collision_InHigh  = 1'b1;
        step();
        bus.SC_LANESCHEDULER_startButton_InLow = 1'b1;
        bus.SC_LANESCHEDULER_collision_InHigh  = 1'b0;
        check_value("startcoll_state", 32'(o_state), 32'd1);
        check_value("startcoll_lives", 32'(o_lives), 32'd3);
        check_value("startcoll_level", 32'(o_level), 32'd0);
        check_value("startcoll_clr", 32'(o_clr), 32'd0);

        // Asynchronous reset in the middle of a run.
        repeat (19) step();
        #2 rst = 1'b1;
        #1 sample();
        check_value("midrun_reset", 32'(obs_vec()), 32'(RST_VEC));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step();
        check_value("post_reset_state", 32'(o_state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
